// File: rtl/morse_decoder_if.sv
//------------------------------------------------------------------------------
// Module      : morse_decoder_if
// Description : Symbol-slot bus between the Morse timing front end and decoder.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface morse_decoder_if;
    logic [1:0] morse_one;
    logic [1:0] morse_two;
    logic [1:0] morse_three;
    logic [1:0] morse_four;
    logic [1:0] morse_five;
    logic       letter_done;
    logic [7:0] ascii_char;

    modport master (
        output morse_one, morse_two, morse_three, morse_four, morse_five,
        output letter_done,
        input  ascii_char
    );

    modport slave (
        input  morse_one, morse_two, morse_three, morse_four, morse_five,
        input  letter_done,
        output ascii_char
    );
endinterface

`default_nettype wire

// File: rtl/morse_decoder.sv
//------------------------------------------------------------------------------
// Module      : morse_decoder
// Description : Decodes five dot/dash symbol slots into registered ASCII.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module morse_decoder (
    input  wire logic        clk,
    input  wire logic        reset,
    morse_decoder_if.slave   bus
);

    localparam logic [7:0] c_UNKNOWN = 8'h3F;

    logic [9:0] w_slots;
    logic [7:0] w_decoded;
    logic [7:0] r_ascii_char;

    assign w_slots = {bus.morse_one, bus.morse_two, bus.morse_three,
                      bus.morse_four, bus.morse_five};

    // Matching the whole slot word means gaps, 2'b11 slots and the all-empty
    // word can never hit a table entry, so they all land on the default.
    always_comb begin
        w_decoded = c_UNKNOWN;
        case (w_slots)
            10'b01_10_00_00_00: w_decoded = 8'h41; // A
            10'b10_01_01_01_00: w_decoded = 8'h42; // B
            10'b10_01_10_01_00: w_decoded = 8'h43; // C
            10'b10_01_01_00_00: w_decoded = 8'h44; // D
            10'b01_00_00_00_00: w_decoded = 8'h45; // E
            10'b01_01_10_01_00: w_decoded = 8'h46; // F
            10'b10_10_01_00_00: w_decoded = 8'h47; // G
            10'b01_01_01_01_00: w_decoded = 8'h48; // H
            10'b01_01_00_00_00: w_decoded = 8'h49; // I
            10'b01_10_10_10_00: w_decoded = 8'h4A; // J
            10'b10_01_10_00_00: w_decoded = 8'h4B; // K
            10'b01_10_01_01_00: w_decoded = 8'h4C; // L
            10'b10_10_00_00_00: w_decoded = 8'h4D; // M
            10'b10_01_00_00_00: w_decoded = 8'h4E; // N
            10'b10_10_10_00_00: w_decoded = 8'h4F; // O
            10'b01_10_10_01_00: w_decoded = 8'h50; // P
            10'b10_10_01_10_00: w_decoded = 8'h51; // Q
            10'b01_10_01_00_00: w_decoded = 8'h52; // R
            10'b01_01_01_00_00: w_decoded = 8'h53; // S
            10'b10_00_00_00_00: w_decoded = 8'h54; // T
            10'b01_01_10_00_00: w_decoded = 8'h55; // U
            10'b01_01_01_10_00: w_decoded = 8'h56; // V
            10'b01_10_10_00_00: w_decoded = 8'h57; // W
            10'b10_01_01_10_00: w_decoded = 8'h58; // X
            10'b10_01_10_10_00: w_decoded = 8'h59; // Y
            10'b10_10_01_01_00: w_decoded = 8'h5A; // Z
            10'b10_10_10_10_10: w_decoded = 8'h30; // 0
            10'b01_10_10_10_10: w_decoded = 8'h31; // 1
            10'b01_01_10_10_10: w_decoded = 8'h32; // 2
            10'b01_01_01_10_10: w_decoded = 8'h33; // 3
            10'b01_01_01_01_10: w_decoded = 8'h34; // 4
            10'b01_01_01_01_01: w_decoded = 8'h35; // 5
            10'b10_01_01_01_01: w_decoded = 8'h36; // 6
            10'b10_10_01_01_01: w_decoded = 8'h37; // 7
            10'b10_10_10_01_01: w_decoded = 8'h38; // 8
            10'b10_10_10_10_01: w_decoded = 8'h39; // 9
            default:            w_decoded = c_UNKNOWN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ascii_char <= 8'h00;
        end else if (bus.letter_done) begin
            r_ascii_char <= w_decoded;
        end
    end

    assign bus.ascii_char = r_ascii_char;

endmodule

`default_nettype wire

// File: tb/tb_morse_decoder.sv
//------------------------------------------------------------------------------
// Module      : tb_morse_decoder
// Description : Self-checking bench for morse_decoder with a string-based model.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_morse_decoder;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    morse_decoder_if bus ();

    morse_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] slots;
        logic       done;
        logic [7:0] exp;
    } vec_t;

    string letters [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.",
                            "....", "..", ".---", "-.-", ".-..", "--", "-.",
                            "---", ".--.", "--.-", ".-.", "...", "-", "..-",
                            "...-", ".--", "-..-", "-.--", "--.."};

    // Digit d: d dots then dashes for 0..5 (0 is all dashes), else d-5 dashes then dots.
    function automatic string digit_code(int d);
        string s;
        s = "";
        for (int i = 0; i < 5; i++) begin
            if (d <= 5) s = {s, ((i < d) ? "." : "-")};
            else        s = {s, ((i < d - 5) ? "-" : ".")};
        end
        return s;
    endfunction

    function automatic logic [9:0] to_slots(string p);
        logic [9:0] v;
        v = '0;
        for (int i = 0; i < p.len() && i < 5; i++)
            v[9 - 2*i -: 2] = (p[i] == 8'h2E) ? 2'b01 : 2'b10;
        return v;
    endfunction

    function automatic logic [7:0] ref_decode(logic [9:0] v);
        string      pat;
        bit         seen_empty;
        bit         bad;
        logic [1:0] sym;
        pat        = "";
        seen_empty = 1'b0;
        bad        = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sym = v[9 - 2*i -: 2];
            if (sym == 2'b11) bad = 1'b1;
            else if (sym == 2'b00) seen_empty = 1'b1;
            else begin
                if (seen_empty) bad = 1'b1;
                pat = {pat, ((sym == 2'b01) ? "." : "-")};
            end
        end
        if (bad || pat.len() == 0) return 8'h3F;
        for (int k = 0; k < 26; k++)
            if (letters[k] == pat) return 8'h41 + 8'(k);
        for (int d = 0; d < 10; d++)
            if (digit_code(d) == pat) return 8'h30 + 8'(d);
        return 8'h3F;
    endfunction

    task automatic drive(logic [9:0] v, logic done);
        {bus.morse_one, bus.morse_two, bus.morse_three,
         bus.morse_four, bus.morse_five} = v;
        bus.letter_done = done;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    vec_t       vecs[$];
    logic [7:0] model_q;
    logic [9:0] rv;
    logic       rd;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(to_slots(".-"), 1'b1);

        // Async reset with no clock edge
        #2 reset = 1'b0;
        #1 check("reset_async", bus.ascii_char, 8'h00);
        tick();
        check("reset_priority", bus.ascii_char, 8'h00);
        reset = 1'b1;
        tick();
        check("reset_release_A", bus.ascii_char, 8'h41);

        // Vector table
        for (int k = 0; k < 26; k++)
            vecs.push_back('{to_slots(letters[k]), 1'b1, 8'h41 + 8'(k)});
        vecs.push_back('{10'b10_01_01_01_00, 1'b1, 8'h42});
        vecs.push_back('{10'b01_10_10_10_00, 1'b1, 8'h4A});
        vecs.push_back('{10'b10_10_01_01_00, 1'b1, 8'h5A});
        vecs.push_back('{10'b10_10_10_10_10, 1'b1, 8'h30});
        vecs.push_back('{10'b01_10_10_10_10, 1'b1, 8'h31});
        vecs.push_back('{10'b01_01_10_10_10, 1'b1, 8'h32});
        vecs.push_back('{10'b01_01_01_10_10, 1'b1, 8'h33});
        vecs.push_back('{10'b01_01_01_01_10, 1'b1, 8'h34});
        vecs.push_back('{10'b01_01_01_01_01, 1'b1, 8'h35});
        vecs.push_back('{10'b10_01_01_01_01, 1'b1, 8'h36});
        vecs.push_back('{10'b10_10_01_01_01, 1'b1, 8'h37});
        vecs.push_back('{10'b10_10_10_01_01, 1'b1, 8'h38});
        vecs.push_back('{10'b10_10_10_10_01, 1'b1, 8'h39});
        vecs.push_back('{10'b00_00_00_00_00, 1'b1, 8'h3F});
        vecs.push_back('{10'b01_00_10_00_00, 1'b1, 8'h3F});
        vecs.push_back('{10'b11_00_00_00_00, 1'b1, 8'h3F});
        vecs.push_back('{10'b01_10_11_00_00, 1'b1, 8'h3F});
        vecs.push_back('{10'b01_01_01_01_11, 1'b1, 8'h3F});
        vecs.push_back('{10'b01_01_10_10_01, 1'b1, 8'h3F});
        vecs.push_back('{10'b01_01_10_10_00, 1'b1, 8'h3F});
        vecs.push_back('{10'b10_01_01_00_00, 1'b0, 8'h3F});
        vecs.push_back('{10'b10_00_00_00_00, 1'b1, 8'h54});

        foreach (vecs[i]) begin
            drive(vecs[i].slots, vecs[i].done);
            tick();
            check($sformatf("vec%0d", i), bus.ascii_char, vecs[i].exp);
        end

        // Hold while letter_done is low
        drive(to_slots("."), 1'b1);
        tick();
        check("hold_capture_E", bus.ascii_char, 8'h45);
        drive(to_slots("-"), 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold_E_%0d", i), bus.ascii_char, 8'h45);
        end
        bus.letter_done = 1'b1;
        tick();
        check("hold_release_T", bus.ascii_char, 8'h54);

        // Async reset mid-stream
        drive(to_slots("--.-"), 1'b1);
        tick();
        check("mid_Q", bus.ascii_char, 8'h51);
        #2 reset = 1'b0;
        #1 check("mid_reset_async", bus.ascii_char, 8'h00);
        tick();
        check("mid_reset_held", bus.ascii_char, 8'h00);
        reset = 1'b1;
        tick();
        check("mid_resume_Q", bus.ascii_char, 8'h51);

        // Randomized stream against the model
        model_q = 8'h51;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(1, 0) == 0) begin
                int c;
                c  = $urandom_range(35, 0);
                rv = (c < 26) ? to_slots(letters[c]) : to_slots(digit_code(c - 26));
            end else begin
                rv = 10'($urandom);
            end
            rd = ($urandom_range(3, 0) != 0);
            drive(rv, rd);
            if (rd) model_q = ref_decode(rv);
            tick();
            check($sformatf("rand%0d_%03h", n, rv), bus.ascii_char, model_q);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/morse_decoder.md
# morse_decoder

Converts one completed Morse character, given as up to five dot/dash symbol slots, into its 8-bit upper-case ASCII code. It sits between the key/timing front end, which fills the symbol slots and pulses `letter_done`, and the display/compare logic of the Morse trainer. The output is registered: a new code is captured on each clock edge where `letter_done` is high, and is held otherwise.

## Interface
- No parameters.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `morse_one` input 2: first symbol slot of the character.
- `morse_two` input 2: second symbol slot.
- `morse_three` input 2: third symbol slot.
- `morse_four` input 2: fourth symbol slot.
- `morse_five` input 2: fifth symbol slot.
- `letter_done` input 1: level-sensitive capture enable; high means the slots hold a complete character.
- `ascii_char` output 8: registered ASCII code of the last captured character.

## Operation
- Symbol encoding per slot:
  - 2'b00 = empty
  - 2'b01 = dot
  - 2'b10 = dash
  - 2'b11 = illegal
- A valid pattern has the following shape:
  - 1 to 5 non-empty symbols packed from `morse_one` upward.
  - All slots after the first empty slot are also empty.
  - No slot is 2'b11.
- Decode table, international Morse, upper case only:
  - Letters A (.-) to Z (--..) map to 0x41–0x5A. Examples: E (.) = 0x45, T (-) = 0x54, Q (--.-) = 0x51, Y (-.--) = 0x59.
  - Digits 0 (-----) to 9 (----.) map to 0x30–0x39. Examples: 1 (.----) = 0x31, 5 (.....) = 0x35, 6 (-....) = 0x36.
- Any pattern not in the table maps to 0x3F ('?'). This includes:
  - all slots empty;
  - a gap (an empty slot followed by a non-empty slot);
  - any 2'b11 slot;
  - well-formed but unassigned codes, such as ..-- or 5-symbol patterns that are not digits.
- The decode is purely combinational. Only `ascii_char` is registered.
- When `letter_done` is high at a rising `clk` edge, `ascii_char` takes the decoded value.
- When `letter_done` is low, `ascii_char` holds its value.
- `letter_done` held high for many cycles re-captures every cycle. The output then tracks slot changes with one cycle of latency.

## Timing
- Reset asserted (`reset`=0): `ascii_char` = 8'h00 immediately, independent of `clk`.
- Reset has priority over `letter_done`.
- Deassertion is synchronized by design intent. The first capture happens on the first rising edge with `reset`=1 and `letter_done`=1.
- Latency: 1 clock. Slots and `letter_done` are sampled at edge N; `ascii_char` is valid after edge N.
- Slot inputs must be stable at the sampling edge only. There are no other handshake requirements.
- Reset asserted mid-sequence clears the output to 0x00. A character being presented that cycle is lost, not captured.

## Test plan
- Reset:
  - Assert `reset`=0 with slots = .- and `letter_done`=1 → `ascii_char`=0x00 with no clock edge.
  - Release reset, then one edge → 0x41.
- Full alphabet sweep with `letter_done`=1, one character per cycle → 0x41..0x5A in order, each one cycle after its slots are applied. Checks include:
  - B (-...) = 0x42
  - J (.---) = 0x4A
  - Z (--..) = 0x5A
- Digit sweep:
  - ----- → 0x30
  - .---- → 0x31
  - ..--- → 0x32
  - ...-- → 0x33
  - ....- → 0x34
  - ..... → 0x35
  - -.... → 0x36
  - --... → 0x37
  - ---.. → 0x38
  - ----. → 0x39
- Hold: capture E (0x45), drop `letter_done` to 0, then apply T for 3 edges → output stays 0x45. Raise `letter_done` → 0x54 after the next edge.
- Invalid patterns, each → 0x3F:
  - all slots 00;
  - slots {01,00,10,00,00} (gap);
  - any slot 11;
  - ..--.
- Async reset mid-stream: `ascii_char`=0x51, pulse `reset` low between edges → 0x00 immediately and held while low. After release, the next edge with `letter_done`=1 resumes decoding.
